// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor_pkg                                                       |
// | Shared counter encodings, instruction size and PC slicing helpers.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int unsigned INSTR_BYTES = 4;

    // Helpers work on a 64-bit view of the PC; callers size the result down.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_bits);
        return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter2                                                               |
// | Next-state logic of a 2-bit saturating up/down counter.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_inc,
    output logic [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_inc) begin
            if (i_cnt != ST) o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != SNT) o_cnt = i_cnt - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_predictor                                                           |
// | Direct-mapped direction/target predictor trained by execute resolution.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH   = 64,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 ex_valid,
    input  logic                 ex_branch,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    input  logic                 ex_pred_taken,
    input  logic [PC_WIDTH-1:0]  ex_pred_target,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int c_ENTRIES = 1 << INDEX_BITS;
    localparam int c_TAG_W   = PC_WIDTH - INDEX_BITS - 2;

    logic                r_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0]  r_tag    [c_ENTRIES];
    logic [PC_WIDTH-1:0] r_target [c_ENTRIES];
    logic [1:0]          r_cnt    [c_ENTRIES];

    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispredict_count;

    logic [INDEX_BITS-1:0] w_if_idx;
    logic [c_TAG_W-1:0]    w_if_tag;
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [c_TAG_W-1:0]    w_ex_tag;
    logic                  w_upd;
    logic                  w_ex_hit;
    logic [1:0]            w_cnt_nxt;

    assign w_if_idx = INDEX_BITS'(pc_index(64'(if_pc), INDEX_BITS));
    assign w_if_tag = c_TAG_W'(pc_tag(64'(if_pc), INDEX_BITS));
    assign w_ex_idx = INDEX_BITS'(pc_index(64'(ex_pc), INDEX_BITS));
    assign w_ex_tag = c_TAG_W'(pc_tag(64'(ex_pc), INDEX_BITS));

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign pred_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken  = pred_hit && r_cnt[w_if_idx][1];
    assign pred_target = pred_taken ? r_target[w_if_idx]
                                    : if_pc + PC_WIDTH'(INSTR_BYTES);

    assign w_upd      = ex_valid && ex_branch;
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign mispredict = w_upd && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + PC_WIDTH'(INSTR_BYTES);

    sat_counter2 u_sat_counter2 (
        .i_cnt (r_cnt[w_ex_idx]),
        .i_inc (ex_taken),
        .o_cnt (w_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= WNT;
            end
        end else if (w_upd) begin
            if (w_ex_hit) begin
                r_cnt[w_ex_idx] <= w_cnt_nxt;
                if (ex_taken) r_target[w_ex_idx] <= ex_target;
            end else if (ex_taken) begin
                // Allocation evicts whatever aliased entry held this index.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_upd && (r_branch_count != '1))
                r_branch_count <= r_branch_count + 1'b1;
            if (mispredict && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + 1'b1;
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_predictor                                                        |
// | Directed self-checking bench with hand-computed expectations.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_branch_predictor;

    localparam int c_PCW = 64;
    localparam int c_CW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [c_PCW-1:0] if_pc;
    logic             pred_hit;
    logic             pred_taken;
    logic [c_PCW-1:0] pred_target;
    logic             ex_valid;
    logic             ex_branch;
    logic [c_PCW-1:0] ex_pc;
    logic             ex_taken;
    logic [c_PCW-1:0] ex_target;
    logic             ex_pred_taken;
    logic [c_PCW-1:0] ex_pred_target;
    logic             mispredict;
    logic [c_PCW-1:0] redirect_pc;
    logic [c_CW-1:0]  branch_count;
    logic [c_CW-1:0]  mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.PC_WIDTH(c_PCW), .INDEX_BITS(4), .CNT_WIDTH(c_CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic [63:0] pc,
                            input logic tk, input logic [63:0] tgt,
                            input logic ptk, input logic [63:0] ptgt);
        ex_valid = v; ex_branch = br; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic ex_idle();
        ex_drive(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic lookup(input logic [63:0] pc, input logic hit, input logic tk,
                          input logic [63:0] tgt, input string tag);
        if_pc = pc;
        #1;
        check({tag, "_hit"}, 64'(pred_hit), 64'(hit));
        check({tag, "_taken"}, 64'(pred_taken), 64'(tk));
        check({tag, "_target"}, pred_target, tgt);
    endtask

    task automatic stats(input int bc, input int mc, input string tag);
        check({tag, "_branch_count"}, 64'(branch_count), 64'(bc));
        check({tag, "_mispredict_count"}, 64'(mispredict_count), 64'(mc));
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 64'h0;
        ex_idle();
        step(); step();
        reset = 1'b0;
        step();

        // Empty table after reset
        lookup(64'h40, 1'b0, 1'b0, 64'h44, "reset_lookup");
        stats(0, 0, "reset");

        // First taken branch allocates at weak-taken
        ex_drive(1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 64'h44);
        check("alloc_mispredict", 64'(mispredict), 64'd1);
        check("alloc_redirect", redirect_pc, 64'h80);
        step();
        ex_idle();
        check("idle_mispredict", 64'(mispredict), 64'd0);
        lookup(64'h40, 1'b1, 1'b1, 64'h80, "after_alloc");
        stats(1, 1, "after_alloc");

        // Three correctly predicted taken branches: WT -> ST, saturated
        for (int i = 0; i < 3; i++) begin
            ex_drive(1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b1, 64'h80);
            check("taken_correct_mispredict", 64'(mispredict), 64'd0);
            step();
        end
        ex_idle();
        stats(4, 1, "after_taken3");

        // First not-taken: ST -> WT, still predicts taken
        ex_drive(1'b1, 1'b1, 64'h40, 1'b0, 64'h80, 1'b1, 64'h80);
        check("nt1_mispredict", 64'(mispredict), 64'd1);
        check("nt1_redirect", redirect_pc, 64'h44);
        step();
        ex_idle();
        lookup(64'h40, 1'b1, 1'b1, 64'h80, "after_nt1");

        // Second not-taken: WT -> WNT, now predicts fall-through
        ex_drive(1'b1, 1'b1, 64'h40, 1'b0, 64'h80, 1'b1, 64'h80);
        check("nt2_mispredict", 64'(mispredict), 64'd1);
        check("nt2_redirect", redirect_pc, 64'h44);
        step();
        ex_idle();
        lookup(64'h40, 1'b1, 1'b0, 64'h44, "after_nt2");
        stats(6, 3, "after_nt2");

        // Same-cycle update and lookup: old counter visible, new one next cycle
        if_pc = 64'h40;
        ex_drive(1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b1, 64'h90);
        check("samecyc_mispredict", 64'(mispredict), 64'd1);
        check("samecyc_redirect", redirect_pc, 64'h80);
        check("samecyc_old_taken", 64'(pred_taken), 64'd0);
        step();
        ex_idle();
        lookup(64'h40, 1'b1, 1'b1, 64'h80, "samecyc_next");
        stats(7, 4, "samecyc");

        // Alias on index 0 with a different tag
        lookup(64'h80, 1'b0, 1'b0, 64'h84, "alias_miss");
        ex_drive(1'b1, 1'b1, 64'h80, 1'b1, 64'h100, 1'b0, 64'h84);
        step();
        ex_idle();
        lookup(64'h80, 1'b1, 1'b1, 64'h100, "alias_new");
        lookup(64'h40, 1'b0, 1'b0, 64'h44, "alias_evicted");
        stats(8, 5, "alias");

        // Non-branch instruction: no mispredict, no state change
        ex_drive(1'b1, 1'b0, 64'h80, 1'b1, 64'h200, 1'b0, 64'h84);
        check("nonbranch_mispredict", 64'(mispredict), 64'd0);
        step();
        // Not-taken miss counts but does not allocate
        ex_drive(1'b1, 1'b1, 64'hC0, 1'b0, 64'h300, 1'b0, 64'hC4);
        check("ntmiss_mispredict", 64'(mispredict), 64'd0);
        step();
        ex_idle();
        lookup(64'hC0, 1'b0, 1'b0, 64'hC4, "ntmiss_noalloc");
        lookup(64'h80, 1'b1, 1'b1, 64'h100, "ntmiss_keep");
        stats(9, 5, "ntmiss");

        // Reset dominates a concurrent update
        reset = 1'b1;
        ex_drive(1'b1, 1'b1, 64'h44, 1'b1, 64'h200, 1'b0, 64'h48);
        check("reset_mispredict", 64'(mispredict), 64'd1);
        check("reset_redirect", redirect_pc, 64'h200);
        step();
        reset = 1'b0;
        ex_idle();
        lookup(64'h44, 1'b0, 1'b0, 64'h48, "reset_noupd");
        lookup(64'h80, 1'b0, 1'b0, 64'h84, "reset_cleared");
        stats(0, 0, "reset_upd");

        // Statistics saturate at all-ones
        for (int i = 0; i < 15; i++) begin
            ex_drive(1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 64'h44);
            step();
        end
        stats(15, 15, "sat_reach");
        for (int i = 0; i < 2; i++) begin
            ex_drive(1'b1, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 64'h44);
            step();
        end
        ex_idle();
        stats(15, 15, "sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
